// File: rtl/table_inv_pkg.sv
// Shared constants and helpers for the table_inv inverse decoder:
// divisor ROM, FSM state type, error codes and the nibble-repeat pattern.
package table_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] ERR_OK         = 2'd0;
  localparam logic [1:0] ERR_BAD_STATUS = 2'd1;
  localparam logic [1:0] ERR_MISMATCH   = 2'd2;
  localparam logic [1:0] ERR_RANGE      = 2'd3;

  // Entry k holds the prime selected by status k+1.
  localparam logic [9:0][5:0] DIV_ROM = {
    6'd53, 6'd47, 6'd43, 6'd41, 6'd37, 6'd31, 6'd29, 6'd23, 6'd19, 6'd17
  };

  localparam logic [15:0] PATTERN = 16'h1111;

  function automatic logic status_legal(input logic [3:0] s);
    return (s >= 4'd1) && (s <= 4'd10);
  endfunction

  function automatic logic [5:0] divisor_of(input logic [3:0] s);
    logic [3:0] idx;
    idx = s - 4'd1;
    if (idx > 4'd9) return 6'd0;
    return DIV_ROM[idx];
  endfunction

  // Status s claims the quotient lies in decade s-1; the end bins are open.
  function automatic logic bin_ok(input logic [3:0] s, input logic [7:0] q);
    int lo, hi;
    lo = (int'(s) - 1) * 10;
    hi = (s == 4'd10) ? 256 : int'(s) * 10;
    return (int'(q) >= lo) && (int'(q) < hi);
  endfunction

endpackage

// File: rtl/table_inv_if.sv
// Request/response handshake bundle between the table mapper and table_inv.
interface table_inv_if #(
  parameter int RESULT_W  = 16,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [RESULT_W-1:0]  in_result;
  logic [3:0]           in_status;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_data;
  logic                 out_err;
  logic [1:0]           out_err_code;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_result, in_status, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err, out_err_code, err_count
  );

  modport slave (
    input  in_valid, in_result, in_status, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err, out_err_code, err_count
  );
endinterface

// File: rtl/table_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor
// if it fits, and emit the quotient bit.
module table_div_step (
  input  logic [5:0] rem_in,
  input  logic       bit_in,
  input  logic [5:0] divisor,
  output logic [5:0] rem_out,
  output logic       q_bit
);
  logic [6:0] trial;

  assign trial   = {rem_in, bit_in};
  assign q_bit   = trial >= {1'b0, divisor};
  // The remainder stays below the divisor (max 53), so six bits always suffice.
  assign rem_out = q_bit ? 6'(trial - {1'b0, divisor}) : trial[5:0];
endmodule

// File: rtl/table_inv.sv
// Inverse table decoder: recovers the 8-bit data word from a (result, status)
// pair using either an iterative divider (mode 0) or a pattern decode (mode 1).
module table_inv
  import table_pkg::*;
#(
  parameter int RESULT_W  = 16,
  parameter int ERR_CNT_W = 8
) (
  input logic        clk,
  input logic        rst,
  table_inv_if.slave bus
);
  localparam int CNT_W = $clog2(RESULT_W + 1);

  state_t               state;
  logic [RESULT_W-1:0]  res_q;
  logic [3:0]           status_q;
  logic [1:0]           mode_q;
  logic [5:0]           rem;
  logic [RESULT_W-1:0]  quo;
  logic [CNT_W-1:0]     step_cnt;

  logic                 out_valid;
  logic [7:0]           out_data;
  logic                 out_err;
  logic [1:0]           out_err_code;
  logic [ERR_CNT_W-1:0] err_count;

  logic [5:0]           divisor;
  logic [5:0]           rem_nxt;
  logic                 q_bit;
  logic [3:0]           nib;
  logic [7:0]           resp_data;
  logic [1:0]           resp_code;

  assign divisor = divisor_of(status_q);
  assign nib     = res_q[3:0];

  // The dividend is consumed MSB first straight out of the latched result.
  table_div_step u_step (
    .rem_in  (rem),
    .bit_in  (res_q[RESULT_W-1]),
    .divisor (divisor),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    resp_data = 8'd0;
    resp_code = ERR_OK;
    if (mode_q == 2'd0) begin
      if (!status_legal(status_q))              resp_code = ERR_BAD_STATUS;
      else if (rem != 6'd0)                     resp_code = ERR_MISMATCH;
      else if (|quo[RESULT_W-1:8])              resp_code = ERR_RANGE;
      else if (!bin_ok(status_q, quo[7:0]))     resp_code = ERR_RANGE;
      else                                      resp_data = quo[7:0];
    end else if (mode_q == 2'd1) begin
      if (res_q != RESULT_W'(PATTERN * 16'(nib))) resp_code = ERR_MISMATCH;
      else                                        resp_data = {status_q, nib - 4'd1};
    end else begin
      resp_code = ERR_BAD_STATUS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state        <= ST_IDLE;
      res_q        <= '0;
      status_q     <= '0;
      mode_q       <= '0;
      rem          <= '0;
      quo          <= '0;
      step_cnt     <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err      <= 1'b0;
      out_err_code <= ERR_OK;
      err_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          res_q    <= bus.in_result;
          status_q <= bus.in_status;
          mode_q   <= bus.in_mode;
          rem      <= '0;
          quo      <= '0;
          step_cnt <= '0;
          state    <= (bus.in_mode == 2'd0 && status_legal(bus.in_status)) ? ST_DIV : ST_CHECK;
        end
        ST_DIV: begin
          res_q    <= res_q << 1;
          rem      <= rem_nxt;
          quo      <= {quo[RESULT_W-2:0], q_bit};
          step_cnt <= step_cnt + CNT_W'(1);
          if (step_cnt == CNT_W'(RESULT_W - 1)) state <= ST_CHECK;
        end
        ST_CHECK: begin
          out_data     <= resp_data;
          out_err      <= resp_code != ERR_OK;
          out_err_code <= resp_code;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          // The response registers settle for one cycle before valid is shown.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
            if (out_err && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == ST_IDLE);
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.out_err      = out_err;
  assign bus.out_err_code = out_err_code;
  assign bus.err_count    = err_count;
endmodule
